// File: rtl/rv32v_pkg.sv
// Shared RV32 vector-extension definitions: opcodes, ALU codes and the
// sequencer's instruction-kind and state encodings.
package rv32v_pkg;

  localparam logic [6:0] X_R      = 7'd51;
  localparam logic [6:0] X_I      = 7'd19;
  localparam logic [6:0] X_I_LOAD = 7'd3;
  localparam logic [6:0] X_S      = 7'd35;
  localparam logic [6:0] X_B      = 7'd99;
  localparam logic [6:0] V_R      = 7'd24;
  localparam logic [6:0] V_I      = 7'd39;
  localparam logic [6:0] V_S      = 7'd67;
  localparam logic [6:0] V_I_LOAD = 7'd44;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;

  // Kind 11 has no dedicated meaning and is executed as an ALU op.
  typedef enum logic [1:0] {
    VK_ALU   = 2'b00,
    VK_LOAD  = 2'b01,
    VK_STORE = 2'b10,
    VK_ALU2  = 2'b11
  } vkind_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALU,
    S_MEM,
    S_DONE
  } vseq_state_t;

endpackage

// File: rtl/vector_sequencer_if.sv
// Issue, VRF and memory-port signals of the vector sequencer.
// master = decode/datapath side, slave = sequencer.
interface vector_sequencer_if
  import rv32v_pkg::*;
#(
  parameter int VLEN_ELEMS = 8
);
  localparam int EW = $clog2(VLEN_ELEMS);

  logic          issue_valid;
  logic          issue_ready;
  vkind_t        issue_kind;
  logic [3:0]    issue_alu_control;
  logic [4:0]    issue_vd;
  logic [4:0]    issue_vs1;
  logic [4:0]    issue_vs2;
  logic [EW:0]   issue_vl;
  logic [4:0]    vrf_rd_addr1;
  logic [4:0]    vrf_rd_addr2;
  logic [EW-1:0] elem_idx;
  logic [3:0]    alu_control;
  logic          vrf_we;
  logic [4:0]    vrf_wr_addr;
  logic          mem_req;
  logic          mem_we;
  logic          mem_ack;
  logic          stall;
  logic          done;

  modport slave (
    input  issue_valid, issue_kind, issue_alu_control, issue_vd, issue_vs1,
           issue_vs2, issue_vl, mem_ack,
    output issue_ready, vrf_rd_addr1, vrf_rd_addr2, elem_idx, alu_control,
           vrf_we, vrf_wr_addr, mem_req, mem_we, stall, done
  );

  modport master (
    output issue_valid, issue_kind, issue_alu_control, issue_vd, issue_vs1,
           issue_vs2, issue_vl, mem_ack,
    input  issue_ready, vrf_rd_addr1, vrf_rd_addr2, elem_idx, alu_control,
           vrf_we, vrf_wr_addr, mem_req, mem_we, stall, done
  );

endinterface

// File: rtl/vec_elem_counter.sv
// Element index counter; last flags the final element of the latched vl.
module vec_elem_counter #(
  parameter int EW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic [EW:0]   vl,
  output logic [EW-1:0] count,
  output logic          last
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + EW'(1);
  end

  assign last = ({1'b0, count} == (vl - (EW+1)'(1)));

endmodule

// File: rtl/vector_sequencer.sv
// Steps one vector instruction element by element through ALU / VRF / memory,
// stalling the scalar pipeline until the done pulse.
module vector_sequencer
  import rv32v_pkg::*;
#(
  parameter int VLEN_ELEMS = 8
) (
  input logic               clk,
  input logic               reset,
  vector_sequencer_if.slave bus
);
  localparam int EW = $clog2(VLEN_ELEMS);
  localparam logic [EW:0] VL_MAX = (EW+1)'(VLEN_ELEMS);

  vseq_state_t   state, state_nx;
  vkind_t        kind_q;
  logic [3:0]    alu_q;
  logic [4:0]    vd_q, vs1_q, vs2_q;
  logic [EW:0]   vl_q, vl_eff;
  logic [EW-1:0] idx;
  logic          accept, last, cnt_en, is_mem_kind;

  assign accept      = bus.issue_valid && (state == S_IDLE);
  assign vl_eff      = (bus.issue_vl > VL_MAX) ? VL_MAX : bus.issue_vl;
  assign is_mem_kind = (bus.issue_kind == VK_LOAD) || (bus.issue_kind == VK_STORE);
  // Holding at the last index keeps the counter from ever wrapping.
  assign cnt_en      = !last && ((state == S_ALU) || ((state == S_MEM) && bus.mem_ack));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q <= VK_ALU;
      alu_q  <= '0;
      vd_q   <= '0;
      vs1_q  <= '0;
      vs2_q  <= '0;
      vl_q   <= '0;
    end else if (accept) begin
      kind_q <= bus.issue_kind;
      alu_q  <= bus.issue_alu_control;
      vd_q   <= bus.issue_vd;
      vs1_q  <= bus.issue_vs1;
      vs2_q  <= bus.issue_vs2;
      vl_q   <= vl_eff;
    end
  end

  vec_elem_counter #(.EW(EW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (cnt_en),
    .vl    (vl_q),
    .count (idx),
    .last  (last)
  );

  always_comb begin
    state_nx        = state;
    bus.issue_ready = (state == S_IDLE);
    bus.stall       = (state != S_IDLE);
    bus.done        = (state == S_DONE);
    bus.mem_req     = (state == S_MEM);
    bus.mem_we      = (state == S_MEM) && (kind_q == VK_STORE);
    bus.vrf_we      = (state == S_ALU) ||
                      ((state == S_MEM) && (kind_q == VK_LOAD) && bus.mem_ack);
    unique case (state)
      S_IDLE: if (accept) begin
        if (vl_eff == '0)     state_nx = S_DONE;
        else if (is_mem_kind) state_nx = S_MEM;
        else                  state_nx = S_ALU;
      end
      S_ALU:   if (last) state_nx = S_DONE;
      S_MEM:   if (bus.mem_ack && last) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.vrf_rd_addr1 = vs1_q;
  assign bus.vrf_rd_addr2 = vs2_q;
  assign bus.vrf_wr_addr  = vd_q;
  assign bus.alu_control  = alu_q;
  assign bus.elem_idx     = idx;

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: table of instructions expanded into
// a per-cycle expectation queue, plus back-to-back and mid-instruction reset cases.
module tb_vector_sequencer;
  import rv32v_pkg::*;

  localparam int VL = 8;
  localparam int EW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vector_sequencer_if #(.VLEN_ELEMS(VL)) bus ();
  vector_sequencer #(.VLEN_ELEMS(VL)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    vkind_t     kind;
    int         vl;
    logic [3:0] alu;
    logic [4:0] vd, vs1, vs2;
    int         wait_n;
    int         exp_we, exp_req, exp_stall;
  } vec_t;

  // obs = {issue_ready, stall, done, vrf_we, mem_req, mem_we}
  typedef struct {
    logic          valid, ack;
    logic [5:0]    obs;
    logic          strobe;
    logic [EW-1:0] idx;
  } step_t;

  step_t sq[$];
  vec_t  tbl[7];
  int    checks = 0, failures = 0;
  int    n_we, n_req, n_stall;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic step_t mk(logic v, logic a, logic rdy, logic dn, logic we,
                               logic req, logic mwe, logic [EW-1:0] idx);
    step_t s;
    s.valid  = v;
    s.ack    = a;
    s.obs    = {rdy, ~rdy, dn, we, req, mwe};
    s.strobe = we | req;
    s.idx    = idx;
    return s;
  endfunction

  task automatic push_idle(logic v);
    sq.push_back(mk(v, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
  endtask

  // Expected per-cycle behaviour after an accept edge, ending with the done cycle.
  task automatic push_instr(vkind_t k, int vl, int wait_n, logic vhold);
    int  eff;
    logic mem, ld, st;
    eff = (vl > VL) ? VL : vl;
    ld  = (k == VK_LOAD);
    st  = (k == VK_STORE);
    mem = ld | st;
    for (int i = 0; i < eff; i++) begin
      if (mem) begin
        for (int j = 0; j <= wait_n; j++)
          sq.push_back(mk(vhold, j == wait_n, 1'b0, 1'b0, ld && (j == wait_n),
                          1'b1, st, EW'(i)));
      end else begin
        sq.push_back(mk(vhold, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, EW'(i)));
      end
    end
    sq.push_back(mk(vhold, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0));
  endtask

  task automatic set_issue(vec_t r);
    bus.issue_kind        = r.kind;
    bus.issue_vl          = (EW+1)'(r.vl);
    bus.issue_alu_control = r.alu;
    bus.issue_vd          = r.vd;
    bus.issue_vs1         = r.vs1;
    bus.issue_vs2         = r.vs2;
  endtask

  task automatic run_steps(string tag, vec_t r, logic latch_chk);
    step_t s;
    n_we = 0; n_req = 0; n_stall = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk);
      bus.issue_valid = s.valid;
      bus.mem_ack     = s.ack;
      if (!s.valid && s.obs[4]) begin
        // upstream is free to change the issue fields once accepted
        bus.issue_vd          = ~r.vd;
        bus.issue_vs1         = ~r.vs1;
        bus.issue_vs2         = ~r.vs2;
        bus.issue_alu_control = ~r.alu;
      end
      #1;
      chk({tag, " ctl"}, {bus.issue_ready, bus.stall, bus.done, bus.vrf_we,
                          bus.mem_req, bus.mem_we}, s.obs);
      if (s.strobe) chk({tag, " elem_idx"}, bus.elem_idx, s.idx);
      if (latch_chk && bus.stall)
        chk({tag, " latched"}, {bus.vrf_wr_addr, bus.vrf_rd_addr1, bus.vrf_rd_addr2,
                                bus.alu_control}, {r.vd, r.vs1, r.vs2, r.alu});
      n_we    += int'(bus.vrf_we);
      n_req   += int'(bus.mem_req);
      n_stall += int'(bus.stall);
    end
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    vec_t r;
    tbl[0] = '{VK_ALU,   4, 4'b0010, 5'd3,  5'd1,  5'd2,  0, 4, 0, 5};
    tbl[1] = '{VK_LOAD,  3, 4'b0000, 5'd7,  5'd4,  5'd5,  2, 3, 9, 10};
    tbl[2] = '{VK_STORE, 9, 4'b0001, 5'd10, 5'd11, 5'd12, 0, 0, 8, 9};
    tbl[3] = '{VK_ALU,   0, 4'b0011, 5'd13, 5'd14, 5'd15, 0, 0, 0, 1};
    tbl[4] = '{VK_ALU2,  8, 4'b0111, 5'd31, 5'd30, 5'd29, 0, 8, 0, 9};
    tbl[5] = '{VK_LOAD,  1, 4'b0100, 5'd16, 5'd17, 5'd18, 0, 1, 1, 2};
    tbl[6] = '{VK_STORE, 2, 4'b0110, 5'd20, 5'd21, 5'd22, 1, 0, 4, 5};

    bus.issue_valid = 1'b0;
    bus.mem_ack     = 1'b0;
    set_issue(tbl[0]);

    // Reset state
    #12;
    chk("reset ctl", {bus.issue_ready, bus.stall, bus.done, bus.vrf_we,
                      bus.mem_req, bus.mem_we}, 6'b100000);
    chk("reset fields", {bus.elem_idx, bus.vrf_wr_addr, bus.vrf_rd_addr1,
                         bus.vrf_rd_addr2, bus.alu_control}, '0);
    @(negedge clk);
    reset = 1'b0;

    // Ten idle cycles; stray mem_ack must be ignored
    for (int i = 0; i < 10; i++)
      sq.push_back(mk(1'b0, i[0], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    run_steps("idle", tbl[0], 1'b0);

    // Table-driven instructions
    for (int t = 0; t < 7; t++) begin
      r = tbl[t];
      set_issue(r);
      push_idle(1'b1);
      push_instr(r.kind, r.vl, r.wait_n, 1'b0);
      push_idle(1'b0);
      run_steps($sformatf("vec%0d", t), r, 1'b1);
      chk($sformatf("vec%0d we_count", t), n_we, r.exp_we);
      chk($sformatf("vec%0d req_count", t), n_req, r.exp_req);
      chk($sformatf("vec%0d stall_count", t), n_stall, r.exp_stall);
    end

    // Back-to-back with issue_valid held: second accept only once ready
    r = '{VK_ALU, 2, 4'b0101, 5'd6, 5'd8, 5'd9, 0, 4, 0, 6};
    set_issue(r);
    push_idle(1'b1);
    push_instr(VK_ALU, 2, 0, 1'b1);
    push_idle(1'b1);
    push_instr(VK_ALU, 2, 0, 1'b0);
    push_idle(1'b0);
    run_steps("b2b", r, 1'b1);
    chk("b2b we_count", n_we, r.exp_we);
    chk("b2b stall_count", n_stall, r.exp_stall);

    // Reset asserted while ALU is on element 2
    r = '{VK_ALU, 5, 4'b0011, 5'd25, 5'd26, 5'd27, 0, 0, 0, 0};
    set_issue(r);
    push_idle(1'b1);
    for (int i = 0; i < 3; i++)
      sq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, EW'(i)));
    run_steps("pre_rst", r, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("midrst ctl", {bus.issue_ready, bus.stall, bus.done, bus.vrf_we,
                       bus.mem_req, bus.mem_we}, 6'b100000);
    chk("midrst fields", {bus.elem_idx, bus.vrf_wr_addr, bus.alu_control}, '0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push_idle(1'b0);
    run_steps("post_rst", r, 1'b0);

    // Next issue restarts at element 0
    r = '{VK_ALU, 3, 4'b0010, 5'd2, 5'd3, 5'd4, 0, 3, 0, 4};
    set_issue(r);
    push_idle(1'b1);
    push_instr(VK_ALU, 3, 0, 1'b0);
    push_idle(1'b0);
    run_steps("restart", r, 1'b1);
    chk("restart we_count", n_we, r.exp_we);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
